clap_pattern_detector: RTL

//  Parametrised successor clap detector. Qualifies claps from a strobed audio sample stream.

---
 rtl/clap_pkg.sv | 33 +++
 rtl/clap_level_cmp.sv | 47 ++++
 rtl/clap_pattern_detector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/clap_pkg.sv
// -----------------------------------------------------------------------------
// clap_pkg
// Shared definitions for the clap pattern detector:
//   clap_state_t  - FSM state enum shared by the detector and anything that
//                   wants to decode its state
//   DEF_*         - default parameter values for the detector and level decode
//   sat_inc       - saturating increment used by the run/quiet/gap counters
// -----------------------------------------------------------------------------
package clap_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM1  = 3'd1,
        HOLD1 = 3'd2,
        GAP   = 3'd3,
        ARM2  = 3'd4,
        HOLD2 = 3'd5
    } clap_state_t;

    localparam int DEF_SAMPLE_W       = 8;
    localparam int DEF_THRESHOLD      = 8;
    localparam int DEF_MIN_HIGH       = 2;
    localparam int DEF_QUIET_SAMPLES  = 4;
    localparam int DEF_WINDOW_SAMPLES = 64;
    localparam int DEF_CNT_W          = 8;

    // Increment that sticks at max_value instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned max_value);
        return (value >= max_value) ? max_value : value + 1;
    endfunction

endpackage

// File: rtl/clap_level_cmp.sv
// -----------------------------------------------------------------------------
// clap_level_cmp
// Purely combinational loudness decode for one audio sample.
//
// Build option (macro CLAP_ABS_EN):
//   defined   : audio_in is two's complement, level = |audio_in|; the most
//               negative code maps to 2^(SAMPLE_W-1), which still fits in
//               SAMPLE_W unsigned bits.
//   undefined : audio_in is unsigned, level = audio_in.
//
// Ports:
//   audio_valid  in   sample strobe
//   audio_in     in   audio sample
//   loud         out  audio_valid & (level > THRESHOLD)
//   quiet        out  audio_valid & ~loud
// -----------------------------------------------------------------------------
module clap_level_cmp
    import clap_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic                audio_valid,
    input  logic [SAMPLE_W-1:0] audio_in,
    output logic                loud,
    output logic                quiet
);

    logic [SAMPLE_W-1:0] level;

`ifdef CLAP_ABS_EN
    always_comb begin
        level = audio_in;
        if (audio_in[SAMPLE_W-1]) begin
            level = SAMPLE_W'(0) - audio_in;
        end
    end
`else
    always_comb begin
        level = audio_in;
    end
`endif

    assign loud  = audio_valid & (32'(level) > 32'(THRESHOLD));
    assign quiet = audio_valid & ~loud;

endmodule

// File: rtl/clap_pattern_detector.sv
// -----------------------------------------------------------------------------
// clap_pattern_detector
// Qualifies claps from a strobed audio sample stream, classifies each clap
// event as single or double, and keeps a saturating clap count. All outputs
// are registered: a pulse appears the cycle after the audio_valid sample
// that caused it.
//
// Build option: macro CLAP_ABS_EN selects signed-magnitude level extraction
// (see clap_level_cmp).
//
// Ports:
//   clk          in   system clock, posedge
//   reset        in   synchronous, active-high
//   audio_valid  in   sample strobe; state and counters only move when high
//   audio_in     in   audio sample
//   clear_count  in   synchronous clear of clap_count (wins over increment)
//   clap_pulse   out  1-cycle pulse per qualified clap
//   single_clap  out  1-cycle pulse: window expired without a second clap
//   double_clap  out  1-cycle pulse: second clap qualified inside window
//   clap_count   out  total qualified claps, saturating at all-ones
//   busy         out  state != IDLE
//
// state | meaning
// IDLE  | waiting for a loud sample
// ARM1  | first clap: counting loud samples toward MIN_HIGH
// HOLD1 | first clap qualified: waiting for QUIET_SAMPLES quiet samples
// GAP   | between claps: gap counter running toward WINDOW_SAMPLES
// ARM2  | second clap: counting loud samples, gap still running
// HOLD2 | second clap qualified: waiting for quiet, then back to IDLE
// -----------------------------------------------------------------------------
module clap_pattern_detector
    import clap_pkg::*;
#(
    parameter int SAMPLE_W       = DEF_SAMPLE_W,
    parameter int THRESHOLD      = DEF_THRESHOLD,
    parameter int MIN_HIGH       = DEF_MIN_HIGH,
    parameter int QUIET_SAMPLES  = DEF_QUIET_SAMPLES,
    parameter int WINDOW_SAMPLES = DEF_WINDOW_SAMPLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                audio_valid,
    input  logic [SAMPLE_W-1:0] audio_in,
    input  logic                clear_count,
    output logic                clap_pulse,
    output logic                single_clap,
    output logic                double_clap,
    output logic [CNT_W-1:0]    clap_count,
    output logic                busy
);

    localparam int RUN_W  = $clog2(MIN_HIGH + 1);
    localparam int QCNT_W = $clog2(QUIET_SAMPLES + 1);
    localparam int GAP_W  = $clog2(WINDOW_SAMPLES + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MIN_HIGH);
    localparam logic [QCNT_W-1:0] QCNT_MAX = QCNT_W'(QUIET_SAMPLES);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(WINDOW_SAMPLES);
    // With MIN_HIGH == 1 the very first loud sample is already a clap.
    localparam logic              QUAL_ON_FIRST = (MIN_HIGH == 1);

    logic loud;
    logic quiet;

    clap_state_t state;
    clap_state_t state_nxt;

    logic [RUN_W-1:0]  run,  run_nxt,  run_inc;
    logic [QCNT_W-1:0] qcnt, qcnt_nxt, qcnt_inc;
    logic [GAP_W-1:0]  gap,  gap_nxt,  gap_inc;

    logic run_hit;
    logic qcnt_hit;
    logic gap_hit;

    logic clap_evt;
    logic single_evt;
    logic double_evt;

    clap_level_cmp #(
        .SAMPLE_W  (SAMPLE_W),
        .THRESHOLD (THRESHOLD)
    ) u_level_cmp (
        .audio_valid (audio_valid),
        .audio_in    (audio_in),
        .loud        (loud),
        .quiet       (quiet)
    );

    // "Hit" flags look at the value the counter is about to take, so the
    // action happens on the sample that makes the count reach its limit.
    assign run_inc  = RUN_W'(sat_inc(32'(run), 32'(MIN_HIGH)));
    assign qcnt_inc = QCNT_W'(sat_inc(32'(qcnt), 32'(QUIET_SAMPLES)));
    assign gap_inc  = GAP_W'(sat_inc(32'(gap), 32'(WINDOW_SAMPLES)));

    assign run_hit  = (run_inc == RUN_MAX);
    assign qcnt_hit = (qcnt_inc == QCNT_MAX);
    assign gap_hit  = (gap_inc == GAP_MAX);

    // State register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            run         <= '0;
            qcnt        <= '0;
            gap         <= '0;
            clap_pulse  <= 1'b0;
            single_clap <= 1'b0;
            double_clap <= 1'b0;
            clap_count  <= '0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            qcnt        <= qcnt_nxt;
            gap         <= gap_nxt;
            clap_pulse  <= clap_evt;
            single_clap <= single_evt;
            double_clap <= double_evt;
            if (clear_count) begin
                clap_count <= '0;
            end else if (clap_evt && (clap_count != '1)) begin
                clap_count <= clap_count + CNT_W'(1);
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        qcnt_nxt  = qcnt;
        gap_nxt   = gap;
        case (state)
            IDLE: begin
                if (loud) begin
                    run_nxt = RUN_W'(1);
                    if (QUAL_ON_FIRST) begin
                        qcnt_nxt  = '0;
                        state_nxt = HOLD1;
                    end else begin
                        state_nxt = ARM1;
                    end
                end
            end
            ARM1: begin
                if (loud) begin
                    run_nxt = run_inc;
                    if (run_hit) begin
                        qcnt_nxt  = '0;
                        state_nxt = HOLD1;
                    end
                end else if (quiet) begin
                    state_nxt = IDLE;
                end
            end
            HOLD1, HOLD2: begin
                if (loud) begin
                    qcnt_nxt = '0;
                end else if (quiet) begin
                    qcnt_nxt = qcnt_inc;
                    if (qcnt_hit) begin
                        gap_nxt   = '0;
                        state_nxt = (state == HOLD1) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                if (audio_valid) begin
                    gap_nxt = gap_inc;
                end
                if (loud) begin
                    run_nxt = RUN_W'(1);
                    if (QUAL_ON_FIRST) begin
                        qcnt_nxt  = '0;
                        state_nxt = HOLD2;
                    end else begin
                        state_nxt = ARM2;
                    end
                end else if (quiet && gap_hit) begin
                    state_nxt = IDLE;
                end
            end
            ARM2: begin
                if (audio_valid) begin
                    gap_nxt = gap_inc;
                end
                // Qualification is checked before expiry so a clap completing
                // on the last window sample still counts as a double.
                if (loud && run_hit) begin
                    run_nxt   = run_inc;
                    qcnt_nxt  = '0;
                    state_nxt = HOLD2;
                end else if (audio_valid && gap_hit) begin
                    state_nxt = IDLE;
                end else if (loud) begin
                    run_nxt = run_inc;
                end else if (quiet) begin
                    state_nxt = GAP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pulse decode, registered in the state-register process.
    always_comb begin
        clap_evt   = 1'b0;
        single_evt = 1'b0;
        double_evt = 1'b0;
        case (state)
            IDLE: begin
                clap_evt = loud & QUAL_ON_FIRST;
            end
            ARM1: begin
                clap_evt = loud & run_hit;
            end
            GAP: begin
                clap_evt   = loud & QUAL_ON_FIRST;
                double_evt = loud & QUAL_ON_FIRST;
                single_evt = quiet & gap_hit;
            end
            ARM2: begin
                clap_evt   = loud & run_hit;
                double_evt = loud & run_hit;
                single_evt = audio_valid & gap_hit & ~(loud & run_hit);
            end
            default: begin
                clap_evt = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
